out_req_fifo: RTL and testbench

OUT_REQ_FIFO -- requirements
Module: out_req_fifo

---
 rtl/out_req_fifo_pkg.sv | 25 ++
 rtl/out_req_fifo_if.sv | 28 ++
 rtl/out_req_fifo_mem.sv | 27 ++
 rtl/out_req_fifo.sv | 145 ++++++++++++++
 tb/tb_out_req_fifo.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/out_req_fifo_pkg.sv
// Shared definitions for the outgoing request FIFO: flit control encodings,
// output FSM state encodings and default build parameters.
package out_req_fifo_pkg;

  // Flit type carried alongside every payload word
  localparam logic [1:0] CTRL_ILLEGAL = 2'b00;
  localparam logic [1:0] CTRL_HEAD    = 2'b01;
  localparam logic [1:0] CTRL_BODY    = 2'b10;
  localparam logic [1:0] CTRL_TAIL    = 2'b11;

  // Output FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Default build parameters
  localparam int DEFAULT_FLIT_W     = 16;
  localparam int DEFAULT_DEPTH      = 16;
  localparam int DEFAULT_RDY_THRESH = 11;

  // A flit type of 00 never describes a real flit
  function automatic logic isLegalCtrl(input logic [1:0] ctrl);
    return ctrl != CTRL_ILLEGAL;
  endfunction

endpackage

// File: rtl/out_req_fifo_if.sv
// Handshake bundle between the upload datapath, the request FIFO and the ring.
// The master side is the upload logic plus the ring; the slave side is the FIFO.
interface out_req_fifo_if #(
  parameter int FLIT_W = 16
);

  logic              v_flit_in;
  logic [FLIT_W-1:0] flit_in;
  logic [1:0]        ctrl_in;
  logic              out_req_fifo_rdy;
  logic              v_flit_out;
  logic [FLIT_W-1:0] flit_out;
  logic [1:0]        ctrl_out;
  logic              ring_rdy_in;
  logic              fsm_state;
  logic              err_ovf;

  modport master (
    output v_flit_in, flit_in, ctrl_in, ring_rdy_in,
    input  out_req_fifo_rdy, v_flit_out, flit_out, ctrl_out, fsm_state, err_ovf
  );

  modport slave (
    input  v_flit_in, flit_in, ctrl_in, ring_rdy_in,
    output out_req_fifo_rdy, v_flit_out, flit_out, ctrl_out, fsm_state, err_ovf
  );

endinterface

// File: rtl/out_req_fifo_mem.sv
// Flit storage for the request FIFO: a register array with one synchronous
// write port and one asynchronous (show-ahead) read port. Not reset.
module out_req_fifo_mem #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 18,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [ENTRY_W-1:0] rd_data_o
);

  logic [ENTRY_W-1:0] memArray [DEPTH];

  // Store an accepted flit at the write pointer
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      memArray[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = memArray[rd_addr_i];

endmodule

// File: rtl/out_req_fifo.sv
// Outgoing request FIFO between the upload FSM and the ring. Buffers typed
// flits, presents the oldest flit show-ahead and tracks packet framing with a
// small IDLE/SEND FSM. Define OUT_REQ_FIFO_STORE_FWD_EN for store-and-forward
// mode (a packet is offered to the ring only once its tail is buffered);
// otherwise the FIFO runs cut-through.
module out_req_fifo
  import out_req_fifo_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int FLIT_W     = DEFAULT_FLIT_W,
  parameter int RDY_THRESH = DEFAULT_RDY_THRESH
) (
  input logic         clk,
  input logic         rst,
  out_req_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(RDY_THRESH);

  logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [0:0]          state_q, state_d;
  logic                errOvf_q, errOvf_d;
  logic [FLIT_W+1:0]   rdEntry;
  logic [1:0]          headCtrl;
  logic                vOut;
  logic                pushAcc;
  logic                pushDrop;
  logic                popFire;
  logic [CNT_W-1:0]    freeCnt;

  out_req_fifo_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (FLIT_W + 2),
    .ADDR_W  (PTR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (pushAcc),
    .wr_addr_i (wrPtr_q),
    .wr_data_i ({bus.ctrl_in, bus.flit_in}),
    .rd_addr_i (rdPtr_q),
    .rd_data_o (rdEntry)
  );

  assign headCtrl = rdEntry[FLIT_W+1:FLIT_W];

`ifdef OUT_REQ_FIFO_STORE_FWD_EN
  logic [CNT_W-1:0] pktCnt_q, pktCnt_d;
  logic             tailPush;
  logic             tailPop;

  assign tailPush = pushAcc && (bus.ctrl_in == CTRL_TAIL);
  assign tailPop  = popFire && (headCtrl == CTRL_TAIL);

  // Count complete packets held in the buffer, one per stored tail flit
  always_comb begin
    pktCnt_d = pktCnt_q;
    case ({tailPush, tailPop})
      2'b10:   pktCnt_d = pktCnt_q + CNT_W'(1);
      2'b01:   pktCnt_d = pktCnt_q - CNT_W'(1);
      default: pktCnt_d = pktCnt_q;
    endcase
  end

  // Packet counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pktCnt_q <= '0;
    end else begin
      pktCnt_q <= pktCnt_d;
    end
  end

  // Idle: wait for a whole packet; mid-packet: keep streaming what is there
  always_comb begin
    if (state_q == ST_SEND) begin
      vOut = (count_q != '0);
    end else begin
      vOut = (pktCnt_q != '0);
    end
  end
`else
  // Cut-through: offer any buffered flit regardless of packet state
  always_comb begin
    vOut = (count_q != '0);
  end
`endif

  assign popFire  = vOut && bus.ring_rdy_in;
  assign pushAcc  = bus.v_flit_in && isLegalCtrl(bus.ctrl_in) &&
                    ((count_q < DEPTH_C) || popFire);
  assign pushDrop = bus.v_flit_in && !pushAcc;

  // Next-state for pointers, occupancy, packet FSM and the sticky error flag
  always_comb begin
    wrPtr_d  = pushAcc ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d  = popFire ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    count_d  = count_q;
    case ({pushAcc, popFire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    state_d  = state_q;
    if (popFire) begin
      if ((state_q == ST_IDLE) && (headCtrl == CTRL_HEAD)) begin
        state_d = ST_SEND;
      end else if ((state_q == ST_SEND) && (headCtrl == CTRL_TAIL)) begin
        state_d = ST_IDLE;
      end
    end
    errOvf_d = errOvf_q || pushDrop ||
               (popFire && (state_q == ST_IDLE) && (headCtrl == CTRL_BODY));
  end

  // Main state registers, cleared asynchronously; flit memory is left alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      errOvf_q <= 1'b0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      errOvf_q <= errOvf_d;
    end
  end

  assign freeCnt              = DEPTH_C - count_q;
  assign bus.out_req_fifo_rdy = (freeCnt >= THRESH_C);
  assign bus.v_flit_out       = vOut;
  assign bus.flit_out         = rdEntry[FLIT_W-1:0];
  assign bus.ctrl_out         = headCtrl;
  assign bus.fsm_state        = state_q;
  assign bus.err_ovf          = errOvf_q;

endmodule

// File: tb/tb_out_req_fifo.sv
// Self-checking bench for out_req_fifo (DEPTH=16, FLIT_W=16, RDY_THRESH=11).
// A reference model tracks occupancy, packet state and the error flag; a
// scoreboard queue holds accepted flits and is popped whenever the model
// expects the ring to take one.
module tb_out_req_fifo;
  import out_req_fifo_pkg::*;

  logic clk;
  logic rst;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [17:0] sbQ [$];
  int          mCount;
  int          mPkt;
  logic        mState;
  logic        mErr;
  logic        expValid;
  logic        popNow;
  logic        pushNow;
  logic [17:0] headEntry;

  out_req_fifo_if #(.FLIT_W(16)) bus ();

  out_req_fifo #(
    .DEPTH      (16),
    .FLIT_W     (16),
    .RDY_THRESH (11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return just after the next rising edge
  task automatic applyStimulus(input logic v, input logic [1:0] c,
                               input logic [15:0] f, input logic rr);
    bus.v_flit_in   = v;
    bus.ctrl_in     = c;
    bus.flit_in     = f;
    bus.ring_rdy_in = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n, input logic rr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, CTRL_ILLEGAL, 16'h0, rr);
  endtask

  task automatic pulseReset();
    rst = 1'b0;
    idleCycles(1, 1'b0);
    rst = 1'b1;
  endtask

  // Reference model and scoreboard, evaluated mid-cycle for the coming edge
  always @(negedge clk) begin
    if (!rst) begin
      mCount = 0;
      mPkt   = 0;
      mState = 1'b0;
      mErr   = 1'b0;
      sbQ.delete();
      checkOutput("rst_valid", 32'(bus.v_flit_out), 32'd0);
      checkOutput("rst_rdy", 32'(bus.out_req_fifo_rdy), 32'd1);
    end else begin
`ifdef OUT_REQ_FIFO_STORE_FWD_EN
      expValid = mState ? (mCount > 0) : (mPkt > 0);
`else
      expValid = (mCount > 0);
`endif
      checkOutput("valid", 32'(bus.v_flit_out), 32'(expValid));
      checkOutput("rdy", 32'(bus.out_req_fifo_rdy), 32'((16 - mCount) >= 11));
      checkOutput("fsm", 32'(bus.fsm_state), 32'(mState));
      checkOutput("err", 32'(bus.err_ovf), 32'(mErr));
      popNow = expValid && bus.ring_rdy_in;
      if (popNow) begin
        checkOutput("sb_nonempty", 32'(sbQ.size() > 0), 32'd1);
        if (sbQ.size() > 0) begin
          headEntry = sbQ.pop_front();
          checkOutput("flit", 32'(bus.flit_out), 32'(headEntry[15:0]));
          checkOutput("ctrl", 32'(bus.ctrl_out), 32'(headEntry[17:16]));
          if (!mState && headEntry[17:16] == CTRL_BODY) mErr = 1'b1;
          if (!mState && headEntry[17:16] == CTRL_HEAD) mState = 1'b1;
          else if (mState && headEntry[17:16] == CTRL_TAIL) mState = 1'b0;
          if (headEntry[17:16] == CTRL_TAIL) mPkt--;
        end
      end
      pushNow = bus.v_flit_in && (bus.ctrl_in != CTRL_ILLEGAL) &&
                ((mCount < 16) || popNow);
      if (bus.v_flit_in && !pushNow) mErr = 1'b1;
      if (pushNow) begin
        sbQ.push_back({bus.ctrl_in, bus.flit_in});
        if (bus.ctrl_in == CTRL_TAIL) mPkt++;
      end
      mCount = mCount + int'(pushNow) - int'(popNow);
    end
  end

  initial begin
    logic [1:0] c;
    rst             = 1'b0;
    bus.v_flit_in   = 1'b0;
    bus.ctrl_in     = CTRL_ILLEGAL;
    bus.flit_in     = '0;
    bus.ring_rdy_in = 1'b0;
    idleCycles(2, 1'b0);
    checkOutput("reset_fsm", 32'(bus.fsm_state), 32'd0);
    checkOutput("reset_err", 32'(bus.err_ovf), 32'd0);
    checkOutput("reset_rdy", 32'(bus.out_req_fifo_rdy), 32'd1);
    rst = 1'b1;

    // Three-flit packet straight through to a ready ring
    applyStimulus(1'b1, CTRL_HEAD, 16'hA000, 1'b1);
    applyStimulus(1'b1, CTRL_BODY, 16'h1234, 1'b1);
    applyStimulus(1'b1, CTRL_TAIL, 16'h5678, 1'b1);
    idleCycles(5, 1'b1);

    // Fill with the ring stalled; ready drops once free space is below 11
    for (int i = 0; i < 16; i++) begin
      c = (i == 0) ? CTRL_HEAD : (i == 15) ? CTRL_TAIL : CTRL_BODY;
      applyStimulus(1'b1, c, 16'h1000 + 16'(i), 1'b0);
      if (i == 4) checkOutput("rdy_at5", 32'(bus.out_req_fifo_rdy), 32'd1);
      if (i == 5) checkOutput("rdy_at6", 32'(bus.out_req_fifo_rdy), 32'd0);
    end
    checkOutput("err_before_ovf", 32'(bus.err_ovf), 32'd0);
    applyStimulus(1'b1, CTRL_HEAD, 16'hDEAD, 1'b0);
    checkOutput("err_full", 32'(bus.err_ovf), 32'd1);

    // Full FIFO with simultaneous push and pop across the pointer wrap
    for (int i = 0; i < 20; i++) begin
      c = (i == 0) ? CTRL_HEAD : (i == 19) ? CTRL_TAIL : CTRL_BODY;
      applyStimulus(1'b1, c, 16'h2000 + 16'(i), 1'b1);
    end
    idleCycles(40, 1'b1);
    checkOutput("drain_full", 32'(sbQ.size()), 32'd0);
    pulseReset();

    // Illegal flit type is refused and flagged
    applyStimulus(1'b1, CTRL_ILLEGAL, 16'hBAD0, 1'b1);
    checkOutput("err_ctrl00", 32'(bus.err_ovf), 32'd1);
    idleCycles(2, 1'b1);
    pulseReset();

    // A body flit reaching the head outside a packet is flagged
    applyStimulus(1'b1, CTRL_BODY, 16'h3001, 1'b1);
    applyStimulus(1'b1, CTRL_TAIL, 16'h3002, 1'b1);
    idleCycles(4, 1'b1);
    checkOutput("err_body_idle", 32'(bus.err_ovf), 32'd1);
    pulseReset();

    // Head visibility depends on forwarding mode; tail always releases it
    applyStimulus(1'b1, CTRL_HEAD, 16'h4000, 1'b1);
`ifdef OUT_REQ_FIFO_STORE_FWD_EN
    checkOutput("head_vis", 32'(bus.v_flit_out), 32'd0);
`else
    checkOutput("head_vis", 32'(bus.v_flit_out), 32'd1);
`endif
    applyStimulus(1'b1, CTRL_BODY, 16'h4001, 1'b1);
    applyStimulus(1'b1, CTRL_BODY, 16'h4002, 1'b1);
    idleCycles(3, 1'b1);
    applyStimulus(1'b1, CTRL_TAIL, 16'h4003, 1'b1);
    checkOutput("tail_vis", 32'(bus.v_flit_out), 32'd1);
    idleCycles(6, 1'b1);
    checkOutput("drain_sf", 32'(sbQ.size()), 32'd0);

    // Reset in the middle of a buffered packet
    applyStimulus(1'b1, CTRL_HEAD, 16'h5000, 1'b0);
    idleCycles(1, 1'b1);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, CTRL_BODY, 16'h5000 + 16'(i), 1'b0);
`ifdef OUT_REQ_FIFO_STORE_FWD_EN
    checkOutput("fsm_pre_rst", 32'(bus.fsm_state), 32'd0);
`else
    checkOutput("fsm_pre_rst", 32'(bus.fsm_state), 32'd1);
`endif
    rst = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(bus.v_flit_out), 32'd0);
    checkOutput("midrst_fsm", 32'(bus.fsm_state), 32'd0);
    checkOutput("midrst_rdy", 32'(bus.out_req_fifo_rdy), 32'd1);
    checkOutput("midrst_err", 32'(bus.err_ovf), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b1, CTRL_HEAD, 16'h6000, 1'b1);
    applyStimulus(1'b1, CTRL_BODY, 16'h6001, 1'b1);
    applyStimulus(1'b1, CTRL_TAIL, 16'h6002, 1'b1);
    idleCycles(6, 1'b1);
    checkOutput("drain_post_rst", 32'(sbQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
